// File: rtl/dense_pkg.sv
// rtl/dense_pkg.sv - memory map, layer dimensions and sequencer states shared by the dense layer block
package dense_pkg;

   localparam int N_IN  = 784;
   localparam int N_OUT = 10;
   localparam int I_W   = $clog2(N_IN);

   localparam logic [13:0] X_BASE = 14'h0000;
   localparam logic [13:0] W_BASE = 14'h1000;
   localparam logic [13:0] B_BASE = 14'h2EA0;
   localparam logic [13:0] Y_BASE = 14'h3000;

   typedef enum logic [2:0] {
      IDLE,
      B_ADDR,
      B_LAT,
      X_ADDR,
      W_ADDR,
      TAIL,
      WRITE,
      DONE
   } state_t;

endpackage

// File: rtl/dense_layer_sequencer_if.sv
// rtl/dense_layer_sequencer_if.sv - start/done control and single-port RAM bus of the dense layer sequencer
interface dense_layer_sequencer_if #(
   parameter int ADDRESS_WIDTH = 14,
   parameter int DATA_WIDTH    = 24
) ();
   logic                     start;
   logic                     busy;
   logic                     done;
   logic [3:0]               pred;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic                     mem_we;
   logic [DATA_WIDTH-1:0]    mem_wdata;
   logic [DATA_WIDTH-1:0]    mem_rdata;

   modport master (
      input  start, mem_rdata,
      output busy, done, pred, mem_addr, mem_we, mem_wdata
   );

   modport slave (
      output start, mem_rdata,
      input  busy, done, pred, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/dense_mac_sat.sv
// rtl/dense_mac_sat.sv - signed multiply-accumulate with bias load, then arithmetic shift and saturation
module dense_mac_sat #(
   parameter int DATA_WIDTH = 24,
   parameter int ACC_WIDTH  = 58,
   parameter int BIAS_SHIFT = 0,
   parameter int OUT_SHIFT  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic                  mac_en_i,
   input  logic [DATA_WIDTH-1:0] bias_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] y_o
);
   localparam int PW = 2 * DATA_WIDTH;
   localparam logic signed [ACC_WIDTH-1:0] MAX_POS =
      ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
   localparam logic signed [ACC_WIDTH-1:0] MIN_NEG = ~MAX_POS;

   logic signed [PW-1:0]        prod;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d, shifted;

   assign prod    = PW'($signed(a_i)) * PW'($signed(b_i));
   assign shifted = acc_q >>> OUT_SHIFT;

   always_comb begin
      acc_d = acc_q;
      if (load_i) begin
         acc_d = ACC_WIDTH'($signed(bias_i)) <<< BIAS_SHIFT;
      end else if (mac_en_i) begin
         acc_d = acc_q + ACC_WIDTH'(prod);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   always_comb begin
      y_o = shifted[DATA_WIDTH-1:0];
      if (shifted > MAX_POS) begin
         y_o = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (shifted < MIN_NEG) begin
         y_o = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end
   end
endmodule

// File: rtl/dense_layer_sequencer.sv
// rtl/dense_layer_sequencer.sv - owns the RAM port while busy: streams B, X and W through the MAC, writes Y, tracks argmax
module dense_layer_sequencer
   import dense_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 14,
   parameter int DATA_WIDTH    = 24,
   parameter int ACC_WIDTH     = 58,
   parameter int BIAS_SHIFT    = 0,
   parameter int OUT_SHIFT     = 0
) (
   input logic                     clk,
   input logic                     rst,
   dense_layer_sequencer_if.master bus
);
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   state_t                   state_q, state_d;
   logic [I_W-1:0]           i_q, i_d;
   logic [3:0]               j_q, j_d;
   logic [ADDRESS_WIDTH-1:0] row_base_q, row_base_d;
   logic [DATA_WIDTH-1:0]    x_q, x_d;
   logic [DATA_WIDTH-1:0]    max_val_q, max_val_d;
   logic [3:0]               max_idx_q, max_idx_d;
   logic [DATA_WIDTH-1:0]    y;
   logic                     mac_load, mac_en;

   dense_mac_sat #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .BIAS_SHIFT (BIAS_SHIFT),
      .OUT_SHIFT  (OUT_SHIFT)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .load_i   (mac_load),
      .mac_en_i (mac_en),
      .bias_i   (bus.mem_rdata),
      .a_i      (x_q),
      .b_i      (bus.mem_rdata),
      .y_o      (y)
   );

   assign bus.pred = max_idx_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         i_q        <= '0;
         j_q        <= '0;
         row_base_q <= '0;
         x_q        <= '0;
         max_val_q  <= '0;
         max_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         row_base_q <= row_base_d;
         x_q        <= x_d;
         max_val_q  <= max_val_d;
         max_idx_q  <= max_idx_d;
      end
   end

   // RAM reads are registered: each state consumes the word addressed by the previous one.
   always_comb begin
      state_d       = state_q;
      i_d           = i_q;
      j_d           = j_q;
      row_base_d    = row_base_q;
      x_d           = x_q;
      max_val_d     = max_val_q;
      max_idx_d     = max_idx_q;
      mac_load      = 1'b0;
      mac_en        = 1'b0;
      bus.busy      = 1'b1;
      bus.done      = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = '0;
      case (state_q)
         IDLE: begin
            bus.busy = 1'b0;
            if (bus.start) begin
               state_d    = B_ADDR;
               j_d        = '0;
               row_base_d = '0;
               max_val_d  = MOST_NEG;
               max_idx_d  = '0;
            end
         end
         B_ADDR: begin
            bus.mem_addr = ADDRESS_WIDTH'(B_BASE) + ADDRESS_WIDTH'(j_q);
            state_d      = B_LAT;
         end
         B_LAT: begin
            mac_load = 1'b1;
            i_d      = '0;
            state_d  = X_ADDR;
         end
         X_ADDR: begin
            bus.mem_addr = ADDRESS_WIDTH'(X_BASE) + ADDRESS_WIDTH'(i_q);
            mac_en       = (i_q != '0);
            state_d      = W_ADDR;
         end
         W_ADDR: begin
            bus.mem_addr = ADDRESS_WIDTH'(W_BASE) + row_base_q + ADDRESS_WIDTH'(i_q);
            x_d          = bus.mem_rdata;
            if (i_q == I_W'(N_IN - 1)) begin
               state_d = TAIL;
            end else begin
               i_d     = i_q + 1'b1;
               state_d = X_ADDR;
            end
         end
         TAIL: begin
            mac_en  = 1'b1;
            state_d = WRITE;
         end
         WRITE: begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = ADDRESS_WIDTH'(Y_BASE) + ADDRESS_WIDTH'(j_q);
            bus.mem_wdata = y;
            // Strictly greater, so ties keep the lowest class index.
            if ($signed(y) > $signed(max_val_q)) begin
               max_val_d = y;
               max_idx_d = j_q;
            end
            row_base_d = row_base_q + ADDRESS_WIDTH'(N_IN);
            if (j_q == 4'(N_OUT - 1)) begin
               state_d = DONE;
            end else begin
               j_d     = j_q + 1'b1;
               state_d = B_ADDR;
            end
         end
         DONE: begin
            bus.busy = 1'b0;
            bus.done = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_dense_layer_sequencer.sv
// tb/tb_dense_layer_sequencer.sv - scoreboard bench: two sequencers (OUT_SHIFT 0 and 4) on private RAM models
module tb_dense_layer_sequencer;
   import dense_pkg::*;

   localparam int AW = 14;
   localparam int DW = 24;
   localparam int RUN_CYCLES = 15720;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dense_layer_sequencer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
   dense_layer_sequencer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus4 ();

   dense_layer_sequencer #(.OUT_SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
   dense_layer_sequencer #(.OUT_SHIFT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.master));

   logic [DW-1:0] mem0 [0:16383];
   logic [DW-1:0] mem4 [0:16383];

   always @(posedge clk) begin
      if (bus0.mem_we) mem0[bus0.mem_addr] <= bus0.mem_wdata;
      bus0.mem_rdata <= mem0[bus0.mem_addr];
      if (bus4.mem_we) mem4[bus4.mem_addr] <= bus4.mem_wdata;
      bus4.mem_rdata <= mem4[bus4.mem_addr];
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [AW+DW-1:0] exp_q0 [$];
   logic [AW+DW-1:0] exp_q4 [$];
   logic [AW+DW-1:0] e0, e4;
   int busy_cnt0 = 0, done_cnt0 = 0, we_cnt0 = 0;
   int busy_cnt4 = 0, done_cnt4 = 0, we_cnt4 = 0;

   always @(negedge clk) begin
      if (bus0.busy) busy_cnt0++;
      if (bus0.done) done_cnt0++;
      if (bus0.mem_we === 1'b1) begin
         we_cnt0++;
         if (exp_q0.size() == 0) begin
            check("y0_unexpected_we", bus0.mem_we, 1'b0);
         end else begin
            e0 = exp_q0.pop_front();
            check("y0_addr", bus0.mem_addr, e0[AW+DW-1:DW]);
            check("y0_data", bus0.mem_wdata, e0[DW-1:0]);
         end
      end
      if (bus4.busy) busy_cnt4++;
      if (bus4.done) done_cnt4++;
      if (bus4.mem_we === 1'b1) begin
         we_cnt4++;
         if (exp_q4.size() == 0) begin
            check("y4_unexpected_we", bus4.mem_we, 1'b0);
         end else begin
            e4 = exp_q4.pop_front();
            check("y4_addr", bus4.mem_addr, e4[AW+DW-1:DW]);
            check("y4_data", bus4.mem_wdata, e4[DW-1:0]);
         end
      end
   end

   function automatic longint rd(input bit u4, input int a);
      return u4 ? longint'($signed(mem4[a])) : longint'($signed(mem0[a]));
   endfunction

   // Reference layer computed straight from the RAM image.
   task automatic push_expect(input bit u4, output logic [3:0] p);
      longint acc, best, y;
      best = -64'sd8388608;
      p = 4'd0;
      for (int j = 0; j < N_OUT; j++) begin
         acc = rd(u4, int'(B_BASE) + j);
         for (int i = 0; i < N_IN; i++)
            acc += rd(u4, int'(X_BASE) + i) * rd(u4, int'(W_BASE) + j * N_IN + i);
         acc = acc >>> (u4 ? 4 : 0);
         y = (acc > 64'sd8388607) ? 64'sd8388607 : (acc < -64'sd8388608) ? -64'sd8388608 : acc;
         if (y > best) begin
            best = y;
            p = 4'(j);
         end
         if (u4) exp_q4.push_back({AW'(int'(Y_BASE) + j), DW'(y)});
         else    exp_q0.push_back({AW'(int'(Y_BASE) + j), DW'(y)});
      end
   endtask

   task automatic fill(input bit u4, input int base, input int n, input logic [DW-1:0] v);
      for (int k = 0; k < n; k++) begin
         if (u4) mem4[base + k] = v;
         else    mem0[base + k] = v;
      end
   endtask

   task automatic pulse_start(input bit s0, input bit s4);
      @(posedge clk); #2;
      bus0.start = s0;
      bus4.start = s4;
      @(posedge clk); #2;
      bus0.start = 1'b0;
      bus4.start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < RUN_CYCLES + 200 && !ok; c++) begin
         @(negedge clk);
         if (bus0.done === 1'b1) ok = 1'b1;
      end
      if (!ok) check("done_timeout", bus0.done, 1'b1);
   endtask

   int  b0, d0, w0, b4, d4, w4;
   bit  ok;
   logic [3:0] p0, p4;

   initial begin
      rst = 1'b1;
      bus0.start = 1'b0;
      bus4.start = 1'b0;
      fill(1'b0, 0, 16384, '0);
      fill(1'b1, 0, 16384, '0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", bus0.busy, 1'b0);
      check("rst_done", bus0.done, 1'b0);
      check("rst_pred", bus0.pred, 4'd0);
      check("rst_we", bus0.mem_we, 1'b0);
      check("rst_addr", bus0.mem_addr, '0);
      check("rst_wdata", bus0.mem_wdata, '0);
      @(posedge clk); #2 rst = 1'b0;

      // Run 1: all-ones on dut0 (with a stray start at cycle 100) alongside X=-2, W=3, OUT_SHIFT=4 on dut4.
      fill(1'b0, int'(X_BASE), N_IN, 24'd1);
      fill(1'b0, int'(W_BASE), N_IN * N_OUT, 24'd1);
      fill(1'b1, int'(X_BASE), N_IN, 24'hFFFFFE);
      fill(1'b1, int'(W_BASE), N_IN * N_OUT, 24'd3);
      push_expect(1'b0, p0);
      push_expect(1'b1, p4);
      b0 = busy_cnt0; d0 = done_cnt0; w0 = we_cnt0;
      b4 = busy_cnt4; d4 = done_cnt4; w4 = we_cnt4;
      pulse_start(1'b1, 1'b1);
      repeat (98) @(posedge clk);
      #2 bus0.start = 1'b1;
      @(posedge clk); #2 bus0.start = 1'b0;
      wait_done(ok);
      check("ones_pred", bus0.pred, p0);
      check("shift_done", bus4.done, 1'b1);
      check("shift_pred", bus4.pred, p4);
      repeat (2) @(negedge clk);
      check("ones_busy_cycles", busy_cnt0 - b0, RUN_CYCLES);
      check("ones_done_cycles", done_cnt0 - d0, 1);
      check("ones_we_cycles", we_cnt0 - w0, 10);
      check("ones_sb_left", exp_q0.size(), 0);
      check("shift_busy_cycles", busy_cnt4 - b4, RUN_CYCLES);
      check("shift_done_cycles", done_cnt4 - d4, 1);
      check("shift_we_cycles", we_cnt4 - w4, 10);
      check("shift_sb_left", exp_q4.size(), 0);

      // Run 2: X=0, random W, B[j]=3*j.
      fill(1'b0, int'(X_BASE), N_IN, 24'd0);
      for (int k = 0; k < N_IN * N_OUT; k++) mem0[int'(W_BASE) + k] = DW'($urandom);
      for (int j = 0; j < N_OUT; j++) mem0[int'(B_BASE) + j] = DW'(3 * j);
      push_expect(1'b0, p0);
      b0 = busy_cnt0; d0 = done_cnt0; w0 = we_cnt0;
      pulse_start(1'b1, 1'b0);
      wait_done(ok);
      check("bias_pred", bus0.pred, p0);
      repeat (2) @(negedge clk);
      check("bias_busy_cycles", busy_cnt0 - b0, RUN_CYCLES);
      check("bias_we_cycles", we_cnt0 - w0, 10);
      check("bias_sb_left", exp_q0.size(), 0);

      // Run 3: saturating rows, interrupted by reset at cycle 5000, then rerun from scratch.
      fill(1'b0, int'(X_BASE), N_IN, 24'h7FFFFF);
      fill(1'b0, int'(W_BASE), N_IN * N_OUT, 24'd0);
      fill(1'b0, int'(W_BASE), N_IN, 24'h7FFFFF);
      fill(1'b0, int'(W_BASE) + N_IN, N_IN, 24'h800001);
      fill(1'b0, int'(B_BASE), N_OUT, 24'd0);
      push_expect(1'b0, p0);
      pulse_start(1'b1, 1'b0);
      repeat (4998) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", bus0.busy, 1'b0);
      check("midrst_we", bus0.mem_we, 1'b0);
      check("midrst_pred", bus0.pred, 4'd0);
      exp_q0.delete();
      w0 = we_cnt0;
      repeat (50) @(negedge clk);
      check("midrst_no_writes", we_cnt0 - w0, 0);
      push_expect(1'b0, p0);
      b0 = busy_cnt0; d0 = done_cnt0; w0 = we_cnt0;
      pulse_start(1'b1, 1'b0);
      wait_done(ok);
      check("sat_pred", bus0.pred, p0);
      repeat (2) @(negedge clk);
      check("sat_busy_cycles", busy_cnt0 - b0, RUN_CYCLES);
      check("sat_done_cycles", done_cnt0 - d0, 1);
      check("sat_we_cycles", we_cnt0 - w0, 10);
      check("sat_sb_left", exp_q0.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
